// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and memory_controller rw-port request codes for mem_req_arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    localparam logic [1:0] MEM_RW_IDLE  = 2'b00;
    localparam logic [1:0] MEM_RW_WRITE = 2'b10;
    localparam logic [1:0] MEM_RW_READ  = 2'b11;

    function automatic logic [1:0] rw_encode(input logic wr);
        return wr ? MEM_RW_WRITE : MEM_RW_READ;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: combinational round-robin search over the request vector,
// starting at rr_ptr and wrapping modulo NUM_REQ.
module rr_priority_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   grant,
    output logic               any_req
);

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return sum[IDX_W-1:0];
    endfunction

    // Scan from the farthest offset back to rr_ptr so the closest requester overwrites the rest.
    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[wrap_idx(rr_ptr, i)]) begin
                grant   = wrap_idx(rr_ptr, i);
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: round-robin front end sharing memory_controller's rw port across NUM_REQ masters.
// Define MEM_ARB_TIMEOUT_EN to abort BUSY transactions after TIMEOUT_CYC cycles with req_err.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_wr,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_done,
    output logic [NUM_REQ-1:0]        req_err,
    output logic [DATA_W-1:0]         req_rdata,
    output logic [1:0]                mem_rw,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    input  logic                      mem_vld
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t       state;
    arb_state_t       next_state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] grant_q;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             timeout_hit;
    logic             start_txn;
    logic             finish_txn;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req     (req_valid),
        .rr_ptr  (rr_ptr),
        .grant   (pick_idx),
        .any_req (pick_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // DONE never arbitrates, giving the finishing master a cycle to drop req_valid.
    always_comb begin
        next_state = state;
        start_txn  = 1'b0;
        finish_txn = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_any) begin
                    start_txn  = 1'b1;
                    next_state = BUSY;
                end
            end
            BUSY: begin
                if (mem_vld || timeout_hit) begin
                    finish_txn = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            grant_q   <= '0;
            mem_rw    <= MEM_RW_IDLE;
            mem_addr  <= '0;
            mem_wdata <= '0;
            req_done  <= '0;
            req_rdata <= '0;
        end else begin
            req_done <= '0;
            if (start_txn) begin
                grant_q   <= pick_idx;
                mem_rw    <= rw_encode(req_wr[pick_idx]);
                mem_addr  <= req_addr[pick_idx*ADDR_W +: ADDR_W];
                mem_wdata <= req_wdata[pick_idx*DATA_W +: DATA_W];
            end
            if (finish_txn) begin
                mem_rw            <= MEM_RW_IDLE;
                req_done[grant_q] <= 1'b1;
                req_rdata         <= mem_vld ? mem_rdata : '0;
                rr_ptr            <= (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
            end
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0]   busy_cnt;
    logic [NUM_REQ-1:0] err_q;

    // busy_cnt holds the number of BUSY cycles already completed; a same-edge mem_vld wins.
    assign timeout_hit = (state == BUSY) && !mem_vld && (busy_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_cnt <= '0;
            err_q    <= '0;
        end else begin
            err_q <= '0;
            if (start_txn) begin
                busy_cnt <= '0;
            end else if (state == BUSY) begin
                busy_cnt <= busy_cnt + CNT_W'(1);
            end
            if (timeout_hit) begin
                err_q[grant_q] <= 1'b1;
            end
        end
    end

    assign req_err = err_q;
`else
    logic [31:0] unused_timeout_cyc;

    assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
    assign timeout_hit        = 1'b0;
    assign req_err            = '0;
`endif

endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Parametrised N-requester front end for the memory controller's single read/write port. It replaces the fixed one-master CPU data port with round-robin arbitration across NUM_REQ masters (CPU mem stage, image processor, SPART, …). It drives the controller's two-bit {valid, read} request encoding and returns completion, read data and optional timeout errors to the granted master. It sits between the masters and memory_controller's rw port.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT_CYC, 255, BUSY cycles before timeout abort (only used with MEM_ARB_TIMEOUT_EN)
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  NUM_REQ  per-master request; held until that master's req_done
- req_wr  input  NUM_REQ  1 = write, 0 = read
- req_addr  input  NUM_REQ*ADDR_W  packed addresses, master i at [i*ADDR_W +: ADDR_W]
- req_wdata  input  NUM_REQ*DATA_W  packed write data
- req_done  output  NUM_REQ  one-cycle completion pulse to granted master
- req_err  output  NUM_REQ  one-cycle timeout flag, coincident with req_done
- req_rdata  output  DATA_W  read data, valid while req_done is high
- mem_rw  output  2  {request valid, read(1)/write(0)}
- mem_addr  output  ADDR_W  latched address
- mem_wdata  output  DATA_W  latched write data
- mem_rdata  input  DATA_W  read data from controller
- mem_vld  input  1  controller completion strobe

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: if any req_valid is high at the clock edge, the picker selects a grant g. It searches from rr_ptr upward, wrapping modulo NUM_REQ. On that edge: latch g, req_addr[g], req_wdata[g] and req_wr[g]; set mem_rw = {1, ~req_wr[g]}; go to BUSY.
- BUSY: hold mem_rw, mem_addr and mem_wdata constant.
  - On an edge with mem_vld=1: register mem_rdata into req_rdata, drive mem_rw=2'b00, set req_done[g]=1, set rr_ptr=(g+1) mod NUM_REQ, go to DONE.
- DONE: one cycle. req_done[g] is high and arbitration is suppressed, so the completing master can drop req_valid. Then go to IDLE.
- Changes to req_valid, req_addr or req_wdata during BUSY or DONE are ignored; the latched transaction completes.
- A master that keeps req_valid high after DONE is a new request, but it competes at lowest priority.
- mem_vld while in IDLE or DONE is ignored.
- Write transactions: req_rdata is still loaded from mem_rdata; its value is don't-care.
- Reset values: state IDLE, rr_ptr 0, mem_rw 2'b00, mem_addr 0, mem_wdata 0, req_done 0, req_err 0, req_rdata 0.
- Reset mid-BUSY aborts the transaction with no req_done, and mem_rw is 2'b00 on the next cycle.

## Timing
- Request to mem_rw valid: 1 cycle (registered on the first edge where req_valid is seen in IDLE).
- mem_vld edge to req_done/req_rdata: the outputs are high in the cycle following that edge, for exactly 1 cycle.
- Minimum back-to-back spacing per transaction: 3 cycles (IDLE→BUSY→DONE), assuming mem_vld in the first BUSY cycle.
- Fairness: each master is served within NUM_REQ grants of asserting req_valid.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- MEM_ARB_TIMEOUT_EN defined: a BUSY-cycle counter, cleared on entry to BUSY, runs during BUSY.
  - When it reaches TIMEOUT_CYC with no mem_vld: go to DONE with req_done[g]=1, req_err[g]=1, req_rdata=0, mem_rw=2'b00, and rr_ptr advanced.
  - mem_vld arriving on the same edge as the timeout wins, and req_err stays 0.
- MEM_ARB_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely; req_err is tied to 0.

## Structure
- Package mem_arb_pkg contains:
  - state enum (IDLE, BUSY, DONE)
  - MEM_RW_IDLE=2'b00, MEM_RW_WRITE=2'b10, MEM_RW_READ=2'b11
  - a function returning the request encoding from a wr bit
- Sub-module rr_priority_picker: combinational; inputs req vector and rr_ptr; outputs grant index and any-request flag.

## Test plan
- Single read: master 1 requests a read at addr 0x100; the controller returns 0xCAFEF00D after 2 BUSY cycles → mem_rw=2'b11 from cycle 1, req_done[1] pulses once, req_rdata=0xCAFEF00D.
- Round robin: all 4 masters hold req_valid with 1-cycle memory latency → grant order 0,1,2,3,0, with each req_done 3 cycles apart.
- Write then hold: master 2 writes 0x55AA to 0x40 and keeps req_valid high while master 3 also requests → master 3 is granted next, then master 2 again; mem_wdata=0x55AA and mem_rw=2'b10 throughout its BUSY.
- Input change in BUSY: master 0 changes req_addr from 0x10 to 0x20 mid-BUSY → mem_addr stays 0x10 until DONE.
- Reset mid-BUSY: assert rst for 1 cycle during BUSY → mem_rw=2'b00, no req_done, next grant goes to master 0.
- With MEM_ARB_TIMEOUT_EN, TIMEOUT_CYC=8, mem_vld never asserted → req_done and req_err pulse together after 8 BUSY cycles, req_rdata=0. A second run with mem_vld on cycle 8 gives req_err=0.
